// File: rtl/an_encoder_30bits.sv
// ----------------------------------------------------------------------------
// an_encoder_30bits
//
// AN-code encoder: W = A * N with A = 18613. It sits in front of the 30-bit
// SEC decoder. The product comes from a serial shift-add multiplier that
// handles one bit of A per clock. This avoids a wide combinational multiplier.
// An encode takes exactly A_BITS edges from the input handshake to out_valid.
//
// Optional build macro: ERR_INJ_EN
//   When it is defined, the ports err_en, err_pos and err_sign exist. They add
//   a single signed power-of-two error (+/- 2^err_pos, modulo 2^W_BITS) to the
//   codeword. Latency is the same in both builds.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   N_in is valid
//   in_ready   encoder is idle and can accept a word (from state only)
//   N_in       data word to encode
//   out_valid  W holds a valid codeword
//   out_ready  consumer accepts W
//   W          codeword A*N (plus the injected error when that is enabled)
//   busy       FSM is not in IDLE
//   err_en     (ERR_INJ_EN only) inject an error into this word
//   err_pos    (ERR_INJ_EN only) bit position of the error
//   err_sign   (ERR_INJ_EN only) 0 = add 2^err_pos, 1 = subtract
// ----------------------------------------------------------------------------
module an_encoder_30bits #(
    parameter int A      = 18613,
    parameter int A_BITS = 15,
    parameter int N_BITS = 30,
    parameter int W_BITS = 46
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] N_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_BITS-1:0] W,
    output logic              busy
`ifdef ERR_INJ_EN
    ,
    input  logic              err_en,
    input  logic [5:0]        err_pos,
    input  logic              err_sign
`endif
);

    localparam int                CNT_W    = $clog2(A_BITS);
    localparam logic [A_BITS-1:0] A_VEC    = A_BITS'(A);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(A_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [W_BITS-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [W_BITS-1:0]  nreg_reg, nreg_next;
    logic [W_BITS-1:0]  w_reg, w_next;
    logic               out_valid_reg, out_valid_next;

    logic               accept;
    logic [W_BITS-1:0]  pp [A_BITS];
    logic [W_BITS-1:0]  partial_sum;
    logic [W_BITS-1:0]  final_word;

    assign accept = (state_reg == IDLE) && in_valid;

    // One pre-shifted partial product per bit of A. The zero bits of A give
    // constant zeros, so the cnt-indexed select reduces to the set bits only.
    for (genvar gi = 0; gi < A_BITS; gi++) begin : g_pp
        if (A_VEC[gi]) begin : g_set
            assign pp[gi] = nreg_reg << gi;
        end else begin : g_clr
            assign pp[gi] = '0;
        end
    end

    assign partial_sum = acc_reg + pp[cnt_reg];

`ifdef ERR_INJ_EN
    logic              err_en_reg;
    logic [5:0]        err_pos_reg;
    logic              err_sign_reg;
    logic [W_BITS-1:0] err_mag;

    // The error controls travel with the word. They are captured on the same
    // edge as N_in, so they may change upstream while the word is multiplied.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_en_reg   <= 1'b0;
            err_pos_reg  <= '0;
            err_sign_reg <= 1'b0;
        end else if (accept) begin
            err_en_reg   <= err_en;
            err_pos_reg  <= err_pos;
            err_sign_reg <= err_sign;
        end
    end

    // Positions outside the codeword give no error at all. The wrap of the
    // add/subtract below is the intended modulo-2^W_BITS behaviour.
    assign err_mag = (err_en_reg && (err_pos_reg < 6'(W_BITS)))
                   ? (W_BITS'(1) << err_pos_reg) : '0;
    assign final_word = err_sign_reg ? (partial_sum - err_mag)
                                     : (partial_sum + err_mag);
`else
    assign final_word = partial_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            nreg_reg      <= '0;
            w_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            nreg_reg      <= nreg_next;
            w_reg         <= w_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        nreg_next      = nreg_reg;
        w_next         = w_reg;
        out_valid_next = out_valid_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    nreg_next  = W_BITS'(N_in);
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = MUL;
                end
            end
            MUL: begin
                acc_next = partial_sum;
                cnt_next = cnt_reg + 1'b1;
                // The last partial product goes straight into W on the same
                // edge. This keeps the latency at exactly A_BITS edges.
                if (cnt_reg == CNT_LAST) begin
                    w_next         = final_word;
                    out_valid_next = 1'b1;
                    state_next     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign W         = w_reg;

endmodule
